// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
// Stage indices address the per-pipeline-register enable/flush vectors.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        MEM_WAIT,
        ERROR
    } state_t;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    localparam int IF_ID      = 0;
    localparam int ID_IX      = 1;
    localparam int IX_IM      = 2;
    localparam int IM_IW      = 3;
    localparam int NUM_STAGES = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: datapath status in, stage enables/flushes and memory strobe out.
// master = the controller, slave = the pipeline datapath.
interface pipeline_hazard_ctrl_if;

    logic [pipe_ctrl_pkg::REG_IDX_W-1:0] id_rs;
    logic [pipe_ctrl_pkg::REG_IDX_W-1:0] id_rt;
    logic                                id_uses_rs;
    logic                                id_uses_rt;
    logic [pipe_ctrl_pkg::REG_IDX_W-1:0] ix_dest;
    logic                                ix_write_to_reg;
    logic                                ix_is_load;
    logic                                im_update_pc;
    logic                                im_mem_access;
    logic                                dmem_ready;

    logic pc_en;
    logic if_id_en;
    logic id_ix_en;
    logic ix_im_en;
    logic im_iw_en;
    logic if_id_flush;
    logic id_ix_flush;
    logic ix_im_flush;
    logic im_iw_flush;
    logic dmem_req;

    modport master (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ix_dest, ix_write_to_reg,
               ix_is_load, im_update_pc, im_mem_access, dmem_ready,
        output pc_en, if_id_en, id_ix_en, ix_im_en, im_iw_en,
               if_id_flush, id_ix_flush, ix_im_flush, im_iw_flush, dmem_req
    );

    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ix_dest, ix_write_to_reg,
               ix_is_load, im_update_pc, im_mem_access, dmem_ready,
        input  pc_en, if_id_en, id_ix_en, ix_im_en, im_iw_en,
               if_id_flush, id_ix_flush, ix_im_flush, im_iw_flush, dmem_req
    );

endinterface

// File: rtl/pipe_hazard_cmp.sv
// Combinational load-use detector: an ID source matches a non-zero IX load destination.
module pipe_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic [REG_IDX_W-1:0] ix_dest,
    input  logic                 ix_write_to_reg,
    input  logic                 ix_is_load,
    output logic                 load_use
);

    logic [REG_IDX_W-1:0] src_reg [2];
    logic [1:0]           src_used;
    logic [1:0]           src_match;

    assign src_reg[0] = id_rs;
    assign src_reg[1] = id_rt;
    assign src_used   = {id_uses_rt, id_uses_rs};

    // Register 0 is hardwired, so a write to it can never create a dependency.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] && ix_write_to_reg &&
                                   (ix_dest != REG_ZERO) && (src_reg[gi] == ix_dest);
        end
    endgenerate

    assign load_use = ix_is_load && (|src_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes for load-use, IM redirects and slow data memory,
// plus a saturating stall counter and a sticky memory-timeout error.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int INIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    pipeline_hazard_ctrl_if.master     hz,
    output logic                       mem_err,
    output logic [CNT_W-1:0]           stall_cycles
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int TMO_W  = $clog2(MEM_TIMEOUT + 1);

    state_t              state_reg, state_next;
    logic [INIT_W-1:0]   init_cnt_reg, init_cnt_next;
    logic [TMO_W-1:0]    tmo_cnt_reg, tmo_cnt_next;
    logic [CNT_W-1:0]    stall_cnt_reg;

    logic                   load_use;
    logic                   mem_busy;
    logic                   pc_en;
    logic [NUM_STAGES-1:0]  stage_en;
    logic [NUM_STAGES-1:0]  stage_flush;
    logic                   dmem_req;

    pipe_hazard_cmp u_cmp (
        .id_rs           (hz.id_rs),
        .id_rt           (hz.id_rt),
        .id_uses_rs      (hz.id_uses_rs),
        .id_uses_rt      (hz.id_uses_rt),
        .ix_dest         (hz.ix_dest),
        .ix_write_to_reg (hz.ix_write_to_reg),
        .ix_is_load      (hz.ix_is_load),
        .load_use        (load_use)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= INIT;
            init_cnt_reg  <= '0;
            tmo_cnt_reg   <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            if ((state_reg == RUN || state_reg == MEM_WAIT) && !pc_en && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        mem_busy      = 1'b0;
        pc_en         = 1'b1;
        stage_en      = '1;
        stage_flush   = '0;
        dmem_req      = 1'b0;

        case (state_reg)
            INIT: begin
                stage_flush = '1;
                if (init_cnt_reg == INIT_W'(INIT_CYCLES - 1))
                    state_next = RUN;
                else
                    init_cnt_next = init_cnt_reg + INIT_W'(1);
            end

            RUN, MEM_WAIT: begin
                // In MEM_WAIT the access is outstanding regardless of what IM shows now.
                mem_busy = (state_reg == MEM_WAIT) || hz.im_mem_access;
                dmem_req = mem_busy;
                if (mem_busy && !hz.dmem_ready) begin
                    pc_en              = 1'b0;
                    stage_en[IF_ID]    = 1'b0;
                    stage_en[ID_IX]    = 1'b0;
                    stage_en[IX_IM]    = 1'b0;
                    stage_flush[IM_IW] = 1'b1;
                    if (state_reg == RUN) begin
                        state_next   = MEM_WAIT;
                        tmo_cnt_next = TMO_W'(1);
                    end else if (tmo_cnt_reg == TMO_W'(MEM_TIMEOUT)) begin
                        state_next = ERROR;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                    end
                end else begin
                    // Memory done (or idle): redirect outranks the load-use bubble.
                    state_next = RUN;
                    if (hz.im_update_pc) begin
                        stage_flush[IF_ID] = 1'b1;
                        stage_flush[ID_IX] = 1'b1;
                        stage_flush[IX_IM] = 1'b1;
                    end else if (load_use) begin
                        pc_en              = 1'b0;
                        stage_en[IF_ID]    = 1'b0;
                        stage_flush[ID_IX] = 1'b1;
                    end
                end
            end

            ERROR: begin
                pc_en    = 1'b0;
                stage_en = '0;
            end

            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign hz.pc_en       = pc_en;
    assign hz.if_id_en    = stage_en[IF_ID];
    assign hz.id_ix_en    = stage_en[ID_IX];
    assign hz.ix_im_en    = stage_en[IX_IM];
    assign hz.im_iw_en    = stage_en[IM_IW];
    assign hz.if_id_flush = stage_flush[IF_ID];
    assign hz.id_ix_flush = stage_flush[ID_IX];
    assign hz.ix_im_flush = stage_flush[IX_IM];
    assign hz.im_iw_flush = stage_flush[IM_IW];
    assign hz.dmem_req    = dmem_req;

    assign mem_err      = (state_reg == ERROR);
    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: driver pushes model expectations each cycle, monitor pops and compares.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 64;
    localparam int INIT_CYCLES = 4;
    localparam int CNT_W       = 16;
    localparam int SAT_W       = 4;
    localparam int SAT_MAX     = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus ();
    pipeline_hazard_ctrl_if sat_bus ();

    logic             mem_err, sat_mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [SAT_W-1:0] sat_stall;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .INIT_CYCLES(INIT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .hz(bus), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .INIT_CYCLES(INIT_CYCLES), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .reset_n(reset_n), .hz(sat_bus), .mem_err(sat_mem_err), .stall_cycles(sat_stall)
    );

    assign sat_bus.id_rs           = bus.id_rs;
    assign sat_bus.id_rt           = bus.id_rt;
    assign sat_bus.id_uses_rs      = bus.id_uses_rs;
    assign sat_bus.id_uses_rt      = bus.id_uses_rt;
    assign sat_bus.ix_dest         = bus.ix_dest;
    assign sat_bus.ix_write_to_reg = bus.ix_write_to_reg;
    assign sat_bus.ix_is_load      = bus.ix_is_load;
    assign sat_bus.im_update_pc    = bus.im_update_pc;
    assign sat_bus.im_mem_access   = bus.im_mem_access;
    assign sat_bus.dmem_ready      = bus.dmem_ready;

    typedef struct {
        logic       rst_n;
        logic [4:0] rs, rt, dest;
        logic       urs, urt, wr, ld, upc, acc, rdy;
    } stim_t;

    typedef struct {
        logic [4:0] en;     // {pc, if_id, id_ix, ix_im, im_iw}
        logic [3:0] fl;     // {if_id, id_ix, ix_im, im_iw}
        logic       req;
        logic       err;
        int         stall;
        int         stall_sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: phase bookkeeping with plain counters.
    int m_init_left = INIT_CYCLES;
    bit m_waiting   = 0;
    int m_wait_n    = 0;
    bit m_err       = 0;
    int m_stalls    = 0;

    function automatic bit load_use(stim_t s);
        if (!(s.ld && s.wr) || s.dest == 5'd0) return 1'b0;
        return (s.urs && s.rs == s.dest) || (s.urt && s.rt == s.dest);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n: 1'b1, rs: 5'd0, rt: 5'd0, dest: 5'd0, urs: 1'b0, urt: 1'b0,
              wr: 1'b0, ld: 1'b0, upc: 1'b0, acc: 1'b0, rdy: 1'b1};
        return s;
    endfunction

    task automatic apply(stim_t s);
        reset_n             = s.rst_n;
        bus.id_rs           = s.rs;
        bus.id_rt           = s.rt;
        bus.id_uses_rs      = s.urs;
        bus.id_uses_rt      = s.urt;
        bus.ix_dest         = s.dest;
        bus.ix_write_to_reg = s.wr;
        bus.ix_is_load      = s.ld;
        bus.im_update_pc    = s.upc;
        bus.im_mem_access   = s.acc;
        bus.dmem_ready      = s.rdy;
    endtask

    task automatic step(stim_t s);
        exp_t e;
        bit   pending;
        @(negedge clk);
        apply(s);
        e.req = 1'b0;
        e.err = 1'b0;
        if (!s.rst_n) begin
            m_init_left = INIT_CYCLES; m_waiting = 0; m_wait_n = 0; m_err = 0; m_stalls = 0;
            e.en = 5'b11111; e.fl = 4'b1111;
        end else if (m_err) begin
            e.en = 5'b00000; e.fl = 4'b0000; e.err = 1'b1;
        end else if (m_init_left > 0) begin
            e.en = 5'b11111; e.fl = 4'b1111;
            m_init_left--;
        end else begin
            pending = m_waiting || s.acc;
            e.req   = pending;
            if (pending && !s.rdy) begin
                e.en = 5'b00001; e.fl = 4'b0001;
                if (!m_waiting) begin
                    m_waiting = 1; m_wait_n = 1;
                end else if (m_wait_n == MEM_TIMEOUT) begin
                    m_err = 1; m_waiting = 0;
                end else begin
                    m_wait_n++;
                end
            end else begin
                m_waiting = 0;
                if (s.upc)              begin e.en = 5'b11111; e.fl = 4'b1110; end
                else if (load_use(s))   begin e.en = 5'b00111; e.fl = 4'b0100; end
                else                    begin e.en = 5'b11111; e.fl = 4'b0000; end
            end
        end
        e.stall     = m_stalls;
        e.stall_sat = (m_stalls > SAT_MAX) ? SAT_MAX : m_stalls;
        if (s.rst_n && !m_err && m_init_left == 0 && e.en[4] == 1'b0) m_stalls++;
        // A stall on the timeout cycle itself still counts.
        else if (s.rst_n && m_err && e.err == 1'b0 && e.en[4] == 1'b0) m_stalls++;
        exp_q.push_back(e);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("enables", {27'd0, bus.pc_en, bus.if_id_en, bus.id_ix_en, bus.ix_im_en, bus.im_iw_en},
                      {27'd0, mon_e.en});
                check("flushes", {28'd0, bus.if_id_flush, bus.id_ix_flush, bus.ix_im_flush, bus.im_iw_flush},
                      {28'd0, mon_e.fl});
                check("dmem_req", {31'd0, bus.dmem_req}, {31'd0, mon_e.req});
                check("mem_err", {31'd0, mem_err}, {31'd0, mon_e.err});
                check("stall_cycles", {16'd0, stall_cycles}, mon_e.stall);
                check("stall_sat", {28'd0, sat_stall}, mon_e.stall_sat);
            end
        end
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst_n = 1'b0;
        apply(s);

        $display("[TB] reset and init drain");
        repeat (3) step(s);
        s = idle();
        repeat (8) step(s);

        $display("[TB] load-use on r5, then r0 (no hazard)");
        s = idle(); s.ld = 1; s.wr = 1; s.dest = 5'd5; s.rs = 5'd5; s.urs = 1;
        step(s);
        step(idle());
        s.dest = 5'd0; s.rs = 5'd0;
        step(s);
        s = idle(); s.ld = 1; s.wr = 1; s.dest = 5'd9; s.rt = 5'd9; s.urt = 1;
        step(s);
        step(idle());

        $display("[TB] memory latency 3");
        s = idle(); s.acc = 1; s.rdy = 0;
        repeat (3) step(s);
        s.rdy = 1;
        step(s);
        step(idle());

        $display("[TB] redirect during memory stall");
        s = idle(); s.acc = 1; s.upc = 1; s.rdy = 0;
        repeat (2) step(s);
        s.rdy = 1;
        step(s);
        step(idle());

        $display("[TB] ready on the timeout cycle");
        s = idle(); s.acc = 1; s.rdy = 0;
        repeat (MEM_TIMEOUT) step(s);
        s.rdy = 1;
        step(s);
        repeat (2) step(idle());

        $display("[TB] memory timeout to error");
        s = idle(); s.acc = 1; s.rdy = 0;
        repeat (MEM_TIMEOUT + 6) step(s);
        repeat (2) step(idle());
        s = idle(); s.rst_n = 0;
        repeat (2) step(s);
        repeat (6) step(idle());

        $display("[TB] reset in the middle of a memory wait");
        s = idle(); s.acc = 1; s.rdy = 0;
        repeat (5) step(s);
        s.rst_n = 0;
        step(s);
        repeat (6) step(idle());

        $display("[TB] stall counter saturation");
        s = idle(); s.ld = 1; s.wr = 1; s.dest = 5'd3; s.rs = 5'd3; s.urs = 1;
        repeat (20) step(s);
        step(idle());

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            s.rst_n = ($urandom_range(0, 299) != 0);
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.dest  = 5'($urandom_range(0, 3));
            s.urs   = 1'($urandom_range(0, 1));
            s.urt   = 1'($urandom_range(0, 1));
            s.wr    = 1'($urandom_range(0, 1));
            s.ld    = ($urandom_range(0, 2) == 0);
            s.upc   = ($urandom_range(0, 7) == 0);
            s.acc   = ($urandom_range(0, 3) == 0);
            s.rdy   = ($urandom_range(0, 9) < 7);
            step(s);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline registers (IF/ID, ID/IX, IX/IM, IM/IW).
- Generates per-stage enable (hold) and flush (bubble) controls, and handles load-use hazards, PC redirects resolved in IM, and multi-cycle data-memory accesses.
- FSM state updates on posedge clk. Outputs are combinational from state and current inputs, so they settle before the negedge-latched pipeline registers sample.
- Also keeps a saturating stall-cycle counter and raises a sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 64, max MEM_WAIT cycles before ERROR (>=2)
- INIT_CYCLES, 4, post-reset drain cycles with all flushes asserted (>=1)
- CNT_W, 16, width of stall_cycles counter

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- id_rs  in  5  source register rs of the instruction in ID
- id_rt  in  5  source register rt of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ix_dest  in  5  destination register of the IX instruction (after dest_reg_sel)
- ix_write_to_reg  in  1  IX instruction writes the register file
- ix_is_load  in  1  IX result comes from memory (res_data_sel = memory)
- im_update_pc  in  1  taken branch/jump resolved in IM
- im_mem_access  in  1  IM instruction performs a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ix_en, ix_im_en, im_iw_en  out  1 each  stage load enables
- if_id_flush, id_ix_flush, ix_im_flush, im_iw_flush  out  1 each  load a bubble (write_to_reg=0, update_pc=0, rw=read, no access)
- dmem_req  out  1  data-memory request strobe
- mem_err  out  1  sticky timeout error
- stall_cycles  out  CNT_W  count of cycles with pc_en=0, saturating

Behaviour:
- Reset (async, reset_n=0):
  - state=INIT, init/timeout counters=0, stall_cycles=0, mem_err=0.
  - While in reset: all enables=1, all flushes=1, dmem_req=0.
- Reset asserted mid-operation aborts any MEM_WAIT immediately. dmem_req drops asynchronously.
- Load-use hazard (LU), evaluated combinationally:
  - LU = ix_is_load & ix_write_to_reg & (ix_dest!=0) & ((id_uses_rs & id_rs==ix_dest) | (id_uses_rt & id_rt==ix_dest)).
  - Register 0 never hazards.
- INIT:
  - Outputs as in reset.
  - Leave to RUN after INIT_CYCLES posedges.
  - Input events are ignored in this state.
- RUN, checked in priority order (highest first):
  1. im_mem_access & !dmem_ready:
     - pc_en..ix_im_en=0; im_iw_en=1, im_iw_flush=1; dmem_req=1.
     - Next state MEM_WAIT, timeout counter=1.
     - Any pending redirect or LU is held frozen and re-evaluated on release.
  2. im_update_pc:
     - All enables=1; if_id_flush=id_ix_flush=ix_im_flush=1.
     - The IM instruction proceeds to IW; a single-cycle redirect.
  3. LU:
     - pc_en=if_id_en=0; id_ix_flush=1; remaining enables=1.
     - Produces exactly one bubble. The load in IM in the next cycle then clears the hazard.
  4. Otherwise: all enables=1, no flushes.
  - dmem_req = im_mem_access whenever the state is RUN.
- Mem access with dmem_ready=1 in the same cycle: no stall; zero added latency.
- MEM_WAIT:
  - dmem_req=1; stall outputs as in RUN case 1; counter increments each cycle.
  - dmem_ready=1: outputs this cycle follow RUN rules 2-4 as if memory were complete. Next state RUN.
  - dmem_ready=0 and counter==MEM_TIMEOUT: next state ERROR.
  - dmem_ready arriving on the timeout cycle wins (completes; no error).
- ERROR:
  - All enables=0, flushes=0, dmem_req=0, mem_err=1.
  - Held until reset_n.
- stall_cycles:
  - +1 on each posedge where pc_en=0 in RUN or MEM_WAIT.
  - Saturates at all-ones; never wraps.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {INIT, RUN, MEM_WAIT, ERROR}
  - REG_IDX_W=5, REG_ZERO=5'd0
  - stage index constants (IF_ID, ID_IX, IX_IM, IM_IW)
- One combinational sub-module, pipe_hazard_cmp, computes LU from the ID sources and the IX destination. It is reused later for forwarding-unit checks.

Test Plan:
- Reset release: reset_n low then high -> all flushes=1 for exactly 4 posedges, then RUN with all enables=1, stall_cycles=0.
- Load-use: ix_is_load=1, ix_write_to_reg=1, ix_dest=5, id_rs=5, id_uses_rs=1 -> one cycle of pc_en=if_id_en=0 and id_ix_flush=1; stall_cycles=1. Repeat with ix_dest=0 -> no stall.
- Memory latency 3: im_mem_access=1 with dmem_ready low for 3 cycles -> 3 cycles with pc_en..ix_im_en=0, im_iw_flush=1, dmem_req=1; resumes on dmem_ready; stall_cycles=3.
- Redirect during mem stall: im_update_pc=1 together with a pending access -> stall first; on the dmem_ready cycle, if_id/id_ix/ix_im_flush=1 and all enables=1.
- Timeout: dmem_ready held low -> mem_err=1 after 64 MEM_WAIT cycles, all enables=0. Variant with dmem_ready on cycle 64 -> no error. Reset clears mem_err.
- Saturation: with CNT_W=4, force 20 stall cycles -> stall_cycles=15.
